// File: rtl/fifo_uart_drain.sv
// fifo_uart_drain: pops two nibbles from the read side of the nibble CDC FIFO
// and sends them as one UART 8N1 byte, first-popped nibble in the low half.
module fifo_uart_drain #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [3:0] fifo_data,
  output logic       fifo_pop,
  output logic       tx,
  output logic       busy,
  output logic [7:0] frames_sent
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    POP_LO,
    WAIT_HI,
    POP_HI,
    START,
    DATA,
    STOP
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    lo_q, lo_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bitIdx_q, bitIdx_d;
  logic          tx_q, tx_d;
  logic [7:0]    frames_q, frames_d;
  logic          baudDone;

  assign baudDone = (baud_q == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lo_q     <= '0;
      shreg_q  <= '0;
      baud_q   <= '0;
      bitIdx_q <= '0;
      tx_q     <= 1'b1;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      shreg_q  <= shreg_d;
      baud_q   <= baud_d;
      bitIdx_q <= bitIdx_d;
      tx_q     <= tx_d;
      frames_q <= frames_d;
    end
  end

  // The high nibble goes straight from fifo_data into the shift register.
  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    shreg_d  = shreg_q;
    baud_d   = baud_q;
    bitIdx_d = bitIdx_q;
    frames_d = frames_q;
    unique case (state_q)
      IDLE: begin
        if (enable && !fifo_empty) begin
          lo_d    = fifo_data;
          state_d = POP_LO;
        end
      end
      POP_LO: state_d = WAIT_HI;
      WAIT_HI: begin
        if (!fifo_empty) begin
          shreg_d = {fifo_data, lo_q};
          state_d = POP_HI;
        end
      end
      POP_HI: begin
        baud_d  = '0;
        state_d = START;
      end
      START: begin
        if (baudDone) begin
          baud_d   = '0;
          bitIdx_d = '0;
          state_d  = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baudDone) begin
          baud_d   = '0;
          shreg_d  = {1'b0, shreg_q[7:1]};
          bitIdx_d = bitIdx_q + 1'b1;
          if (bitIdx_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baudDone) begin
          baud_d   = '0;
          frames_d = frames_q + 1'b1;
          state_d  = IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // tx is registered, so it follows the state being entered.
    tx_d = 1'b1;
    if (state_d == START) begin
      tx_d = 1'b0;
    end else if (state_d == DATA) begin
      tx_d = shreg_d[0];
    end
  end

  always_comb begin
    fifo_pop = (state_q == POP_LO) || (state_q == POP_HI);
    busy     = (state_q != IDLE);
  end

  assign tx          = tx_q;
  assign frames_sent = frames_q;

endmodule

// File: tb/tb_fifo_uart_drain.sv
// tb_fifo_uart_drain: feeds the drain from a show-ahead nibble FIFO model and
// decodes its UART line against a scoreboard of expected bytes.
module tb_fifo_uart_drain;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       fifoEmpty = 1'b1;
  logic [3:0] fifoData = 4'h0;
  logic       fifoPop;
  logic       tx;
  logic       busy;
  logic [7:0] framesSent;

  int testsRun = 0;
  int testsFailed = 0;
  int cycleCnt = 0;

  logic [3:0] fifoQ[$];
  logic [3:0] pendingQ[$];
  logic [7:0] expectQ[$];
  int         popCycles[$];
  int         frameStarts[$];

  fifo_uart_drain #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .fifo_empty (fifoEmpty),
    .fifo_data  (fifoData),
    .fifo_pop   (fifoPop),
    .tx         (tx),
    .busy       (busy),
    .frames_sent(framesSent)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Registered-empty FIFO: pops and pushes land on the edge, flags follow it.
  always @(posedge clk) begin
    if (fifoPop === 1'b1) begin
      checkOutput("popWhenNonEmpty", {31'd0, fifoQ.size() > 0}, 32'd1);
      if (fifoQ.size() > 0) void'(fifoQ.pop_front());
    end
    while (pendingQ.size() > 0) fifoQ.push_back(pendingQ.pop_front());
    fifoEmpty <= (fifoQ.size() == 0);
    fifoData  <= (fifoQ.size() > 0) ? fifoQ[0] : 4'h0;
  end

  always @(negedge clk) begin
    if (fifoPop === 1'b1) popCycles.push_back(cycleCnt);
  end

  // UART receiver: every cycle of every bit must hold the same level.
  initial begin : rxMonitor
    logic [7:0] rxByte;
    bit framingOk;
    bit aborted;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        frameStarts.push_back(cycleCnt);
        rxByte = 8'h00;
        framingOk = 1'b1;
        aborted = 1'b0;
        for (int b = 0; b < 10 && !aborted; b++) begin
          for (int c = 0; c < CPB && !aborted; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (rst_n !== 1'b1) aborted = 1'b1;
            else if (b == 0) framingOk &= (tx === 1'b0);
            else if (b == 9) framingOk &= (tx === 1'b1);
            else if (c == 0) rxByte[b-1] = tx;
            else framingOk &= (tx === rxByte[b-1]);
          end
        end
        if (!aborted) begin
          checkOutput("frameShape", {31'd0, framingOk}, 32'd1);
          checkOutput("frameExpected", {31'd0, expectQ.size() > 0}, 32'd1);
          if (expectQ.size() > 0) checkOutput("frameByte", {24'd0, rxByte}, {24'd0, expectQ.pop_front()});
        end
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] byteVal, input bit expectIt);
    pendingQ.push_back(byteVal[3:0]);
    pendingQ.push_back(byteVal[7:4]);
    if (expectIt) expectQ.push_back(byteVal);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitIdleFrames(input logic [7:0] target, input int bound, input string name);
    int k = 0;
    while (!(framesSent == target && busy == 1'b0) && k < bound) begin
      waitCycles(1);
      k++;
    end
    checkOutput(name, {23'd0, busy, framesSent}, {24'd0, target});
  endtask

  task automatic waitForStart(input int idx, input int bound, input string name);
    int k = 0;
    while (frameStarts.size() <= idx && k < bound) begin
      waitCycles(1);
      k++;
    end
    checkOutput(name, {31'd0, frameStarts.size() > idx}, 32'd1);
  endtask

  function automatic int popAt(input int idx);
    return (idx < popCycles.size()) ? popCycles[idx] : -1;
  endfunction

  function automatic int startAt(input int idx);
    return (idx < frameStarts.size()) ? frameStarts[idx] : -1;
  endfunction

  initial begin : stimulus
    int base;
    int popIdx;
    int startIdx;

    // Reset with data already waiting in the FIFO.
    applyStimulus(8'hA5, 1'b1);
    waitCycles(3);
    checkOutput("resetTx", {31'd0, tx}, 32'd1);
    checkOutput("resetPop", {31'd0, fifoPop}, 32'd0);
    checkOutput("resetBusy", {31'd0, busy}, 32'd0);
    checkOutput("resetFrames", {24'd0, framesSent}, 32'd0);

    // Single byte 0xA5: pops at +1/+3, start bit at +4, idle at +44.
    base = cycleCnt;
    popIdx = popCycles.size();
    startIdx = frameStarts.size();
    rst_n = 1'b1;
    enable = 1'b1;
    waitIdleFrames(8'd1, 200, "singleFrames");
    checkOutput("singleEndCycle", cycleCnt, base + 44);
    checkOutput("singlePopLo", popAt(popIdx), base + 1);
    checkOutput("singlePopHi", popAt(popIdx + 1), base + 3);
    checkOutput("singlePopCount", popCycles.size() - popIdx, 2);
    checkOutput("singleStart", startAt(startIdx), base + 4);

    // High-nibble starvation: park in WAIT_HI until 0xC arrives.
    popIdx = popCycles.size();
    expectQ.push_back(8'hC3);
    pendingQ.push_back(4'h3);
    waitCycles(20);
    checkOutput("starveBusy", {31'd0, busy}, 32'd1);
    checkOutput("starveTx", {31'd0, tx}, 32'd1);
    checkOutput("starvePops", popCycles.size() - popIdx, 1);
    pendingQ.push_back(4'hC);
    waitIdleFrames(8'd2, 200, "starveFrames");
    checkOutput("starvePopsTotal", popCycles.size() - popIdx, 2);

    // Back-to-back traffic: three frames, 4 idle-level cycles between them.
    popIdx = popCycles.size();
    startIdx = frameStarts.size();
    applyStimulus(8'h21, 1'b1);
    applyStimulus(8'h43, 1'b1);
    applyStimulus(8'h65, 1'b1);
    waitIdleFrames(8'd5, 500, "b2bFrames");
    checkOutput("b2bStarts", frameStarts.size() - startIdx, 3);
    checkOutput("b2bGap1", startAt(startIdx + 1) - startAt(startIdx) - 40, 4);
    checkOutput("b2bGap2", startAt(startIdx + 2) - startAt(startIdx + 1) - 40, 4);
    checkOutput("b2bPops", popCycles.size() - popIdx, 6);
    checkOutput("b2bEmpty", {31'd0, fifoEmpty}, 32'd1);

    // Enable dropped during DATA of frame 1.
    startIdx = frameStarts.size();
    applyStimulus(8'h87, 1'b1);
    applyStimulus(8'hB9, 1'b1);
    waitForStart(startIdx, 50, "gateStart1");
    waitCycles(10);
    enable = 1'b0;
    popIdx = popCycles.size();
    waitIdleFrames(8'd6, 200, "gateFrame1");
    waitCycles(20);
    checkOutput("gateNoPop", popCycles.size() - popIdx, 0);
    checkOutput("gateIdle", {31'd0, busy}, 32'd0);
    base = cycleCnt;
    popIdx = popCycles.size();
    startIdx = frameStarts.size();
    enable = 1'b1;
    waitIdleFrames(8'd7, 200, "gateFrame2");
    checkOutput("gatePopLo", popAt(popIdx), base + 1);
    checkOutput("gatePopHi", popAt(popIdx + 1), base + 3);
    checkOutput("gateStart2", startAt(startIdx), base + 4);

    // Reset pulse in the middle of a data bit that is currently 0.
    startIdx = frameStarts.size();
    applyStimulus(8'hED, 1'b0);
    waitForStart(startIdx, 50, "rstStart");
    waitCycles(10);
    popIdx = popCycles.size();
    rst_n = 1'b0;
    waitCycles(1);
    checkOutput("rstTx", {31'd0, tx}, 32'd1);
    checkOutput("rstBusy", {31'd0, busy}, 32'd0);
    checkOutput("rstFrames", {24'd0, framesSent}, 32'd0);
    rst_n = 1'b1;
    waitCycles(50);
    checkOutput("rstNoPop", popCycles.size() - popIdx, 0);
    checkOutput("rstStaysIdle", {31'd0, busy}, 32'd0);

    // 256 frames: the counter reaches 255, then wraps to 0.
    for (int i = 0; i < 256; i++) applyStimulus(8'(i), 1'b1);
    waitIdleFrames(8'd255, 12000, "wrap255");
    waitIdleFrames(8'd0, 200, "wrapTo0");
    checkOutput("scoreboardDrained", expectQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/fifo_uart_drain.md
# fifo_uart_drain

Read-side consumer for the nibble CDC FIFO. Pops two 4-bit entries, packs them into one byte (first nibble popped = low nibble), and transmits it as a UART 8N1 frame on a single output pin. Runs in the FIFO read-clock domain: its `clk` is the clock driving the FIFO's `read_clock`, so `fifo_empty` and `fifo_data` need no synchronisation here.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 16: `clk` cycles per UART bit. Legal range is 2..255. The baud counter width is `$clog2(CLKS_PER_BIT)`.

Ports:
- `clk`  in  1  clock; the same net as the FIFO read clock.
- `rst_n`  in  1  reset; synchronous and active-low.
- `enable`  in  1  permits starting a new byte. Sampled only in IDLE.
- `fifo_empty`  in  1  FIFO empty flag. Registered in the `clk` domain.
- `fifo_data`  in  4  FIFO head entry (show-ahead). Valid while `fifo_empty` = 0.
- `fifo_pop`  out  1  one-cycle pop strobe, wired to the FIFO `read_increment`.
- `tx`  out  1  UART serial line. Idle level is 1.
- `busy`  out  1  high when the state is not IDLE.
- `frames_sent`  out  8  count of completed frames. Wraps from 255 to 0.

## Operation

States: IDLE, POP_LO, WAIT_HI, POP_HI, START, DATA, STOP.
- **IDLE:** if `enable` && !`fifo_empty`: `lo` <= `fifo_data`, then go to POP_LO. Otherwise stay.
- **POP_LO:** `fifo_pop` = 1 for exactly this cycle, then go to WAIT_HI.
- **WAIT_HI:** `fifo_empty` now reflects the post-pop state.
  - If !`fifo_empty`: `hi` <= `fifo_data`, `shreg` <= {`hi`,`lo`} (loaded via `fifo_data` directly), then go to POP_HI.
  - Otherwise stay indefinitely. There is no timeout, and `enable` is ignored here.
- **POP_HI:** `fifo_pop` = 1 for exactly this cycle, then go to START. The baud counter is cleared.
- **START:** `tx` = 0 for `CLKS_PER_BIT` cycles, then go to DATA with `bit_idx` = 0.
- **DATA:** `tx` = `shreg`[0]. Every `CLKS_PER_BIT` cycles, shift right and increment `bit_idx`. After 8 bits, go to STOP.
- **STOP:** `tx` = 1 for `CLKS_PER_BIT` cycles. In the last cycle, `frames_sent` += 1 and the next state is IDLE.

General rules:
- Bits go out LSB first: `lo`[0..3], then `hi`[0..3].
- `fifo_pop` is a Moore output of POP_LO and POP_HI only. It is never asserted while `fifo_empty` = 1 was seen in the capturing cycle.
- `tx` is registered. It is 1 in IDLE, POP_LO, WAIT_HI and POP_HI.
- `enable` deasserted mid-operation:
  - The current byte completes, including the wait for the high nibble.
  - No new byte starts until `enable` = 1 again.

## Timing

- **Reset values:** `tx` = 1, `fifo_pop` = 0, `busy` = 0, `frames_sent` = 0. State is IDLE and the counters are 0.
- **Reset asserted mid-frame:** on the next edge, `tx` = 1 and `busy` = 0. Any popped nibble is discarded; the FIFO is not un-popped.
- **Start latency:** both nibbles available and `enable` = 1 sampled at edge E0:
  - POP_LO during E0→E1.
  - WAIT_HI during E1→E2.
  - POP_HI during E2→E3.
  - `tx` falls at edge E3.
- **Frame length:** exactly `10*CLKS_PER_BIT` cycles of `tx` from the falling edge of the start bit to the end of the stop bit.
- **Back-to-back frames:** STOP's last cycle leads to IDLE. IDLE re-tests immediately, so the gap between frames is 1 idle cycle plus 3 pop-handshake cycles, all with `tx` = 1.
- **`busy`:** goes high on the edge that leaves IDLE and low on the edge that enters IDLE.
- **`frames_sent`:** updates on that same edge (the one entering IDLE).
- **Pop spacing:** pops are always at least 2 cycles apart, which guarantees the FIFO's registered empty flag is current at each capture.

## Test plan

- **Reset value check:** hold `rst_n` = 0 for 3 cycles with `fifo_empty` = 0. Required: `tx` = 1, `fifo_pop` = 0, `busy` = 0, `frames_sent` = 0.
- **Single byte:** FIFO model holds 0x5 then 0xA, `CLKS_PER_BIT` = 4, `enable` = 1. Required:
  - `fifo_pop` pulses at cycles 1 and 3.
  - Byte 0xA5 on `tx`: bits 1,0,1,0,0,1,0,1, framed by start 0 and stop 1, 40 cycles total.
  - `frames_sent` = 1.
- **High-nibble starvation:** FIFO holds only 0x3. Required:
  - One pop, then `busy` = 1 with `tx` = 1 held in WAIT_HI.
  - Push 0xC 20 cycles later: byte 0xC3 is transmitted and exactly 2 pops occur in total.
- **Back-to-back traffic:** 6 nibbles queued. Required:
  - 3 frames, each separated by exactly 4 `tx` = 1 cycles.
  - 6 pops, with the last pop leaving `fifo_empty` = 1.
  - `frames_sent` = 3.
- **Enable gating:** deassert `enable` during DATA of frame 1 with 4 nibbles queued. Required: frame 1 completes and no pop occurs until `enable` returns; then frame 2 starts with the 4-cycle latency.
- **Reset mid-frame and wrap:**
  - Pulse `rst_n` low during DATA. Required: `tx` = 1 on the next edge and no further pops.
  - Separately, force 256 frames. Required: `frames_sent` wraps from 255 to 0.
